spike_event_queue: RTL and testbench
====================================

# spike_event_queue

Downstream consumer of the neuron sheet: samples the sheet's per-cycle spike identifier and membrane voltage, detects new spike events, timestamps them and buffers them in a small FIFO. The buffered events are presented to the readout/router stage over a valid/ready handshake. It decouples the free-running sheet, which never stalls, from a readout path that may back-pressure.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- TS_W, 16, timestamp counter width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- spike_id  in  8  sheet spike identifier; 0 = no spike this cycle.
- v_in  in  16  sheet membrane voltage, sampled alongside spike_id.
- ev_valid  out  1  head event available.
- ev_ready  in  1  consumer accepts head event.
- ev_id  out  8  head event spike id.
- ev_time  out  TS_W  head event timestamp.
- ev_v  out  16  head event voltage snapshot.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one event dropped since reset.
- drop_cnt  out  16  dropped-event count (only with SPIKE_QUEUE_DROP_CNT_EN).

## Operation
- Input register stage: spike_id, v_in and timestamp are registered every cycle as s_id, s_v, s_ts.
- Edge detection: an event is produced when s_id != 0 and s_id != prev_id, where prev_id is the s_id of the previous cycle. A spike held constant for several cycles therefore yields one event. A change between two non-zero ids yields a new event.
- Timestamp: a free-running TS_W-bit counter, 0 after reset, +1 every cycle, wrapping from all-ones to 0. The event carries the counter value captured in the input stage.
- Push: when an event is produced and the FIFO is not full, or a pop occurs in the same cycle, {s_id, s_ts, s_v} is written at the tail.
- Pop: occurs when ev_valid && ev_ready. The head advances. ev_ready while ev_valid=0 is ignored.
- Full with no pop: the event is dropped, overflow is set to 1 and held until reset, and drop_cnt increments, saturating at 0xFFFF.
- Full with simultaneous pop: the push is accepted and level is unchanged.
- Empty with push: no fall-through. The event appears on ev_* the cycle after the write.
- ev_id, ev_time and ev_v hold the head entry while ev_valid=1 and remain stable until popped. When empty they hold their last value and must not be relied on.
- ev_valid, once asserted, stays high until a pop.
- Reset mid-operation: the FIFO is flushed immediately. Pointers, level, prev_id, timestamp, overflow and drop_cnt are cleared. Events in flight are lost.

## Timing
- Reset values: ev_valid=0, ev_id=0, ev_time=0, ev_v=0, level=0, overflow=0, drop_cnt=0.
- Latency: spike_id change at sampling edge N → registered at N → written at N+1 → ev_valid=1 after edge N+1. This is 2 cycles from input to visible output.
- level updates on the same edge as the push/pop that changes it.
- Throughput: 1 push and 1 pop per cycle sustained.
- No combinational path from ev_ready to any output.

## Configuration
- SPIKE_QUEUE_DROP_CNT_EN defined: the 16-bit saturating drop_cnt register and port exist as described.
- Not defined: no counter register, and the drop_cnt port is tied to 0. overflow is still implemented.

## Structure
- Shared package spike_pkg:
  - spike_event_t struct {id[7:0], time[TS_W-1:0], v[15:0]}.
  - SPIKE_ID_NONE = 8'd0.
  - Default DEPTH and TS_W constants.
- One sub-module, spike_fifo: synchronous single-clock FIFO of spike_event_t with push/pop/full/empty/level.
- The top holds the input stage, edge detector, timestamp counter, overflow and drop logic.

## Test plan
- Reset, then spike_id 0→5 held for 4 cycles with v_in=100, ev_ready=1 → exactly one event {id 5, v 100, time = counter value at sampling}, ev_valid 2 cycles after the change.
- spike_id sequence 3,7,7,0,7 → events 3, 7, 7 in that order with increasing timestamps.
- ev_ready=0, DEPTH=8, 10 distinct spikes → level=8, overflow=1, drop_cnt=2 (macro on) or 0 (macro off). Draining yields the first 8 ids in order.
- FIFO full, push and pop in the same cycle → level stays 8, the new event is stored, drop_cnt is unchanged.
- Run past 65535 cycles, then spike → ev_time has wrapped to a small value, and ordering by FIFO position is preserved.
- Assert reset with 4 queued events → on the next edge ev_valid=0, level=0, overflow=0, timestamp restarts at 0.

Source files
------------

// File: rtl/spike_pkg.sv
// spike_pkg: shared types and constants for the spike event queue slice.
//   spike_event_t  - packed event record {id, ts, v} at default widths
//                    (the timestamp field is "ts"; "time" is a reserved word)
//   SPIKE_ID_NONE  - sheet spike identifier meaning "no spike this cycle"
//   SPIKE_DEPTH_DEF / SPIKE_TS_W_DEF - default FIFO depth and timestamp width
//   is_new_spike() - event-edge predicate on the registered spike id
package spike_pkg;

  localparam int unsigned SPIKE_DEPTH_DEF = 8;
  localparam int unsigned SPIKE_TS_W_DEF  = 16;

  localparam logic [7:0] SPIKE_ID_NONE = 8'd0;

  typedef struct packed {
    logic [7:0]                id;
    logic [SPIKE_TS_W_DEF-1:0] ts;
    logic [15:0]               v;
  } spike_event_t;

  // A spike is new when it is non-zero and differs from last cycle's id,
  // so a held id yields one event and an id-to-id change yields another.
  function automatic logic is_new_spike(input logic [7:0] cur_id,
                                        input logic [7:0] prev_id);
    return (cur_id != SPIKE_ID_NONE) && (cur_id != prev_id);
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous single-clock FIFO holding packed spike events.
// The head entry is read straight from storage, so a write into an empty
// FIFO becomes visible on head_data the cycle after the write edge.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (flushes contents)
//   push         - write request; accepted when not full or popping
//   push_data    - entry written at the tail
//   pop          - read request; ignored when empty
//   head_data    - current head entry
//   full, empty  - occupancy flags
//   level        - current occupancy, 0..DEPTH
module spike_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned EW    = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [EW-1:0]            push_data,
  input  logic                     pop,
  output logic [EW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  assign head_data = mem[rd_ptr];
  assign level     = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_queue.sv
// spike_event_queue: samples the neuron sheet's spike id and voltage every
// cycle, turns id edges into timestamped events and buffers them for a
// back-pressuring readout over a valid/ready handshake.
// Optional feature macro: SPIKE_QUEUE_DROP_CNT_EN enables the 16-bit
// saturating drop counter; without it drop_cnt is tied to 0.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   spike_id  - sheet spike id, 0 = none
//   v_in      - sheet membrane voltage
//   ev_valid  - head event available
//   ev_ready  - consumer accepts head event
//   ev_id, ev_time, ev_v - head event fields
//   level     - FIFO occupancy
//   overflow  - sticky, an event was dropped since reset
//   drop_cnt  - dropped-event count (saturating)
module spike_event_queue
  import spike_pkg::*;
#(
  parameter int unsigned DEPTH = SPIKE_DEPTH_DEF,
  parameter int unsigned TS_W  = SPIKE_TS_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             spike_id,
  input  logic [15:0]            v_in,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [7:0]             ev_id,
  output logic [TS_W-1:0]        ev_time,
  output logic [15:0]            ev_v,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned EW = 8 + TS_W + 16;

  logic [TS_W-1:0] ts;
  logic [7:0]      s_id;
  logic [15:0]     s_v;
  logic [TS_W-1:0] s_ts;
  logic [7:0]      prev_id;

  logic            ev_det;
  logic            pop;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   head_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts      <= '0;
      s_id    <= SPIKE_ID_NONE;
      s_v     <= '0;
      s_ts    <= '0;
      prev_id <= SPIKE_ID_NONE;
    end else begin
      ts      <= ts + 1'b1;
      s_id    <= spike_id;
      s_v     <= v_in;
      s_ts    <= ts;
      prev_id <= s_id;
    end
  end

  assign ev_det   = is_new_spike(s_id, prev_id);
  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  assign drop     = ev_det && fifo_full && !pop;

  spike_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (ev_det),
    .push_data ({s_id, s_ts, s_v}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign {ev_id, ev_time, ev_v} = head_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef SPIKE_QUEUE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_event_queue.sv
// Testbench for spike_event_queue: directed steps with a scoreboard of
// expected events, pushed when stimulus is driven and compared on pop.
module tb_spike_event_queue;
  import spike_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TS_W  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       spike_id = '0;
  logic [15:0]      v_in = '0;
  logic             ev_ready = 1'b0;
  logic             ev_valid;
  logic [7:0]       ev_id;
  logic [TS_W-1:0]  ev_time;
  logic [15:0]      ev_v;
  logic [3:0]       level;
  logic             overflow;
  logic [15:0]      drop_cnt;

  spike_event_queue #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spike_id (spike_id),
    .v_in     (v_in),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_id    (ev_id),
    .ev_time  (ev_time),
    .ev_v     (ev_v),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int           vectors = 0;
  int           miscompares = 0;
  spike_event_t exp_q[$];
  spike_event_t s_stage;
  logic         s_valid;
  logic [7:0]   prev_drv;
  int           cyc;
  logic         exp_ovf;
  logic [15:0]  exp_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: checks current outputs against the model, advances the model
  // with the inputs now applied, then moves to 1 time unit past the edge.
  task automatic cycle();
    logic do_pop;
    logic do_push;
    check("ev_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
    check("level", 32'(level), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    do_pop = (exp_q.size() != 0) && ev_ready;
    if (do_pop) begin
      check("ev_id", 32'(ev_id), 32'(exp_q[0].id));
      check("ev_time", 32'(ev_time), 32'(exp_q[0].ts));
      check("ev_v", 32'(ev_v), 32'(exp_q[0].v));
    end
    do_push = s_valid && ((exp_q.size() < DEPTH) || do_pop);
    if (s_valid && !do_push) begin
      exp_ovf = 1'b1;
`ifdef SPIKE_QUEUE_DROP_CNT_EN
      if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(s_stage);
    s_valid  = (spike_id != 8'd0) && (spike_id != prev_drv);
    s_stage  = {spike_id, 16'(cyc), v_in};
    prev_drv = spike_id;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset    = 1'b1;
    cyc      = 0;
    exp_q.delete();
    s_valid  = 1'b0;
    prev_drv = 8'd0;
    exp_ovf  = 1'b0;
    exp_drop = 16'd0;
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [15:0] exp_full_drop;
    seq = '{8'd3, 8'd7, 8'd7, 8'd0, 8'd7};
`ifdef SPIKE_QUEUE_DROP_CNT_EN
    exp_full_drop = 16'd2;
`else
    exp_full_drop = 16'd0;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_ev_id", 32'(ev_id), 32'd0);
    check("rst_ev_time", 32'(ev_time), 32'd0);
    check("rst_ev_v", 32'(ev_v), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    release_reset();

    // Held spike gives one event, visible two edges after the change
    ev_ready = 1'b1;
    spike_id = 8'd5;
    v_in     = 16'd100;
    cycle();
    check("lat_edge1_valid", 32'(ev_valid), 32'd0);
    cycle();
    check("lat_edge2_valid", 32'(ev_valid), 32'd1);
    check("t1_id", 32'(ev_id), 32'd5);
    check("t1_time", 32'(ev_time), 32'd0);
    check("t1_v", 32'(ev_v), 32'd100);
    cycle();
    cycle();
    spike_id = 8'd0;
    v_in     = 16'd0;
    repeat (3) cycle();
    check("t1_single_drained", 32'(level), 32'd0);

    // Sequence 3,7,7,0,7 -> events 3,7,7
    for (int i = 0; i < 5; i++) begin
      spike_id = seq[i];
      v_in     = 16'(200 + i);
      cycle();
    end
    spike_id = 8'd0;
    repeat (4) cycle();

    // Fill with back-pressure: 10 distinct spikes into 8 entries
    ev_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike_id = 8'(10 + i);
      v_in     = 16'(i * 3);
      cycle();
    end
    spike_id = 8'd0;
    repeat (3) cycle();
    check("full_level", 32'(level), 32'd8);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_drop_cnt", 32'(drop_cnt), 32'(exp_full_drop));

    // Full with push and pop on the same edge
    spike_id = 8'd50;
    v_in     = 16'd500;
    cycle();
    spike_id = 8'd0;
    ev_ready = 1'b1;
    cycle();
    ev_ready = 1'b0;
    check("pp_level", 32'(level), 32'd8);
    check("pp_drop_cnt", 32'(drop_cnt), 32'(exp_full_drop));
    cycle();
    ev_ready = 1'b1;
    repeat (10) cycle();
    check("drain_level", 32'(level), 32'd0);
    ev_ready = 1'b0;

    // Reset with 4 queued events
    for (int i = 0; i < 4; i++) begin
      spike_id = 8'(60 + i);
      cycle();
    end
    spike_id = 8'd0;
    repeat (2) cycle();
    check("pre_rst_level", 32'(level), 32'd4);
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(ev_valid), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_valid", 32'(ev_valid), 32'd0);
    check("rst_edge_level", 32'(level), 32'd0);
    check("rst_edge_drop_cnt", 32'(drop_cnt), 32'd0);
    release_reset();
    spike_id = 8'd70;
    v_in     = 16'd7;
    cycle();
    spike_id = 8'd0;
    cycle();
    check("post_rst_id", 32'(ev_id), 32'd70);
    check("post_rst_time", 32'(ev_time), 32'd0);
    ev_ready = 1'b1;
    repeat (2) cycle();
    ev_ready = 1'b0;

    // Timestamp wrap with FIFO ordering preserved
    while (cyc < 65533) cycle();
    for (int i = 0; i < 5; i++) begin
      spike_id = 8'(80 + i);
      v_in     = 16'(i);
      cycle();
    end
    spike_id = 8'd0;
    repeat (2) cycle();
    check("wrap_level", 32'(level), 32'd5);
    check("wrap_head_time", 32'(ev_time), 32'hFFFD);
    ev_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
    cycle();
    check("wrap_drained", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
